// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: shared prescaler plus NUM_CH programmable dividers.
// Optional one-shot channel mode is compiled in with `define TICK_ONESHOT_EN.
module tick_gen_multi #(
  parameter int SYS_CLK = 100_000_000,
  parameter int BASE_HZ = 1_000_000,
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 1000,
  localparam int WR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_ch_en,
  input  logic [NUM_CH-1:0] i_clr,
  input  logic              i_wr_en,
  input  logic [WR_W-1:0]   i_wr_ch,
  input  logic [DIV_W-1:0]  i_wr_div,
  input  logic [NUM_CH-1:0] i_arm,
  input  logic [NUM_CH-1:0] i_oneshot,
  output logic              o_tick_base,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_armed
);

  localparam int PRESCALE = SYS_CLK / BASE_HZ;
  localparam int PW       = $clog2(PRESCALE);

  logic [PW-1:0] pcnt;
  logic          base_s;

  assign base_s = (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt        <= '0;
      o_tick_base <= 1'b0;
    end else begin
      pcnt        <= base_s ? '0 : pcnt + PW'(1);
      o_tick_base <= base_s;
    end
  end

`ifndef TICK_ONESHOT_EN
  logic unused_os;
  assign unused_os = ^{i_arm, i_oneshot};
`endif

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] lim;
    logic             tick_q;
    logic             armed_q;
    logic             wr_hit;
    logic             term;
    logic             arm_p;
    logic             os_m;
    logic             run;

`ifdef TICK_ONESHOT_EN
    assign arm_p = i_arm[n] & i_oneshot[n];
    assign os_m  = i_oneshot[n];
`else
    assign arm_p = 1'b0;
    assign os_m  = 1'b0;
`endif

    // a stored divisor of 0 behaves as 1, so the limit is 0 either way
    assign lim    = (div_q == '0) ? '0 : div_q - DIV_W'(1);
    assign term   = (cnt_q >= lim);
    assign wr_hit = i_wr_en && (i_wr_ch == WR_W'(n));
    assign run    = i_ch_en[n] && (!os_m || armed_q);

    always_ff @(posedge clk) begin
      if (rst) begin
        div_q   <= DIV_W'(DEF_DIV);
        cnt_q   <= '0;
        tick_q  <= 1'b0;
        armed_q <= 1'b0;
      end else begin
        if (wr_hit)
          div_q <= i_wr_div;
        if (i_clr[n]) begin
          cnt_q   <= '0;
          tick_q  <= 1'b0;
          armed_q <= 1'b0;
        end else if (arm_p) begin
          cnt_q   <= '0;
          tick_q  <= 1'b0;
          armed_q <= 1'b1;
        end else if (base_s && run) begin
          if (term) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
            if (os_m)
              armed_q <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + DIV_W'(1);
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
      end
    end

    assign o_tick[n]  = tick_q;
    assign o_armed[n] = armed_q;
  end

endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
- Parametrised multi-channel tick generator; successor to the fixed 1 MHz tick generator.
- One shared prescaler derives a base tick of BASE_HZ from the system clock.
- NUM_CH independent channels divide the base tick by runtime-programmable divisors, producing one-clock strobes.
- Feeds sensor trigger/timeout logic, sampling strobes and display refresh.

Parameters:
- SYS_CLK, 100_000_000, system clock frequency in Hz.
- BASE_HZ, 1_000_000, base tick frequency in Hz. PRESCALE = SYS_CLK/BASE_HZ must be an integer >= 2.
- NUM_CH, 4, number of channels, 1..16.
- DIV_W, 16, divisor and channel counter width.
- DEF_DIV, 1000, reset value of every channel divisor.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; all state is cleared on a clk edge while rst is high
- i_ch_en  in  NUM_CH  per-channel run enable (level)
- i_clr  in  NUM_CH  per-channel counter clear (pulse)
- i_wr_en  in  1  divisor write strobe
- i_wr_ch  in  max(1,$clog2(NUM_CH))  channel index for the write
- i_wr_div  in  DIV_W  new divisor value
- i_arm  in  NUM_CH  one-shot arm pulse; used only with TICK_ONESHOT_EN
- i_oneshot  in  NUM_CH  per-channel one-shot mode select; used only with TICK_ONESHOT_EN
- o_tick_base  out  1  base tick strobe, one clk wide
- o_tick  out  NUM_CH  channel tick strobes, one clk wide
- o_armed  out  NUM_CH  one-shot armed status

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. All registers and outputs reset to 0, except div[n], which resets to DEF_DIV.
- Prescaler: counter runs 0..PRESCALE-1 continuously.
  - Internal strobe base_s is true when the counter equals PRESCALE-1; on that edge the counter wraps to 0.
  - o_tick_base is registered from base_s.
  - First o_tick_base pulse occurs PRESCALE cycles after rst is released, then every PRESCALE cycles. The prescaler is never gated.
- Channel n, evaluated on each clk edge:
  - If i_clr[n]: cnt[n] <= 0 and o_tick[n] <= 0. Clear has priority over everything below.
  - Else if base_s and i_ch_en[n]: if cnt[n] >= eff_div-1, then cnt[n] <= 0 and o_tick[n] <= 1; otherwise cnt[n] increments and o_tick[n] <= 0.
  - Otherwise: cnt[n] holds and o_tick[n] <= 0.
- Divisor rules:
  - eff_div = div[n], except a stored value of 0 is treated as 1.
  - With eff_div = 1 the channel ticks on every base tick.
- Timing: o_tick[n] is always coincident with o_tick_base. The channel period is eff_div × PRESCALE cycles.
- Divisor write:
  - When i_wr_en is high, div[i_wr_ch] <= i_wr_div on that edge.
  - If i_wr_ch >= NUM_CH, the write is ignored.
  - cnt is not reset by a write.
  - If a write coincides with base_s for the same channel, that edge's comparison uses the old divisor.
  - If the new divisor is at or below the current count, the `>=` compare makes the channel tick on its next base tick; no wrap-through to 2^DIV_W occurs.
- Enable:
  - Deasserting i_ch_en freezes cnt. Reasserting it resumes from the frozen count.
  - Enable changes take effect on the edge where they are sampled.
- Reset mid-operation: all counters, strobes and arm flags return to 0 on the next edge. Divisors return to DEF_DIV. Any pending strobe is lost.
- Arithmetic: all compares are unsigned, DIV_W wide. The counter never exceeds 2^DIV_W-1.

Optional Feature:
- Macro name: TICK_ONESHOT_EN.
- Defined — channels with i_oneshot[n] = 1 run in one-shot mode:
  - i_arm[n] sets armed[n] and clears cnt[n].
  - The channel counts only while armed and i_ch_en[n] are both high.
  - On reaching the terminal count it emits one o_tick[n] and clears armed[n].
  - i_clr[n] also clears armed[n].
  - An i_arm while already armed restarts the count.
  - o_armed reflects armed[].
  - Channels with i_oneshot[n] = 0 behave as periodic channels.
- Undefined:
  - i_arm and i_oneshot are ignored.
  - o_armed is tied to 0.
  - All channels are periodic.

Test Plan:
- Release rst with i_ch_en = 4'b0001 and default parameters → o_tick_base is high at cycle 100 and every 100 cycles after. o_tick[0] first fires at cycle 100_000, then every 100_000 cycles, coincident with o_tick_base. o_tick[3:1] stay 0.
- Write div = 5 to ch2, then enable ch2 → o_tick[2] fires every 500 cycles, always aligned with o_tick_base.
- Write div = 0 to ch1 and enable it → o_tick[1] fires on every base tick (100-cycle period).
- With ch0 div = 1000 and cnt at 600, write div = 10 → ch0 ticks on the next base tick, then every 1000 cycles. Repeat with the write landing on a base_s edge → the old divisor governs that edge.
- Pulse i_clr[0] mid-count → next tick arrives 1000 base ticks later. Assert rst mid-count → all outputs 0 next cycle, divisors back to 1000, first base tick 100 cycles after release.
- With TICK_ONESHOT_EN defined, i_oneshot[3] = 1, div = 10: pulse i_arm[3] → o_armed[3] = 1 until exactly one o_tick[3] on the 10th base tick, then no further ticks. With the macro undefined → periodic ticks and o_armed = 0.
